// File: rtl/clock_pkg.sv
// Shared clocking definitions: sequencer state encodings and helpers.
// Combinational only, no latency.
// No flow control.
package clock_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 core_clk cycles from input change to sync_dat.
// No backpressure; samples every clock.
module sync_2ff (
    input  logic core_clk,
    input  logic arst_n,
    input  logic async_dat,
    output logic sync_dat
);

    logic meta_q;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_q   <= 1'b0;
            sync_dat <= 1'b0;
        end else begin
            meta_q   <= async_dat;
            sync_dat <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer with staggered downstream channel reset release.
// Latency: outputs registered; lock changes seen 3 clocks after pll_locked moves.
// No backpressure; soft_reset_req wins over every other event in the same clock.
module pll_lock_sequencer
    import clock_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int LOSS_W         = 8
) (
    input  logic               clock_in,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               soft_reset_req,
    output logic               pll_resetb,
    output logic [NUM_CH-1:0]  ch_reset_n,
    output logic               all_ready,
    output logic [LOSS_W-1:0]  lock_loss_count,
    output logic               timeout_err,
    output logic [STATE_W-1:0] state_dbg
);

    // One shared counter serves every state; it is cleared on each transition.
    localparam int CNT_MAX = max_int(max_int(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                     max_int(STABLE_CYCLES, NUM_CH * STAGGER_CYCLES));
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

    seq_state_t        state_q;
    seq_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [NUM_CH-1:0] ch_nxt;
    logic [NUM_CH-1:0] rls_mask;
    logic              pll_resetb_nxt;
    logic              ready_nxt;
    logic [LOSS_W-1:0] loss_nxt;
    logic              terr_nxt;
    logic              lock_s;

    sync_2ff u_lock_sync (
        .core_clk  (clock_in),
        .arst_n    (reset_n),
        .async_dat (pll_locked),
        .sync_dat  (lock_s)
    );

    assign cnt_inc   = cnt_q + 1'b1;
    assign state_dbg = state_q;

    // Channel k is released once the release counter reaches k*STAGGER_CYCLES.
    always_comb begin
        rls_mask = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rls_mask[k] = (32'(cnt_inc) >= 32'(k * STAGGER_CYCLES));
        end
    end

    always_comb begin
        state_nxt      = state_q;
        cnt_nxt        = cnt_q;
        ch_nxt         = ch_reset_n;
        pll_resetb_nxt = pll_resetb;
        ready_nxt      = all_ready;
        loss_nxt       = lock_loss_count;
        terr_nxt       = timeout_err;

        if (soft_reset_req) begin
            state_nxt      = ST_PLL_RST;
            cnt_nxt        = '0;
            ch_nxt         = '0;
            pll_resetb_nxt = 1'b0;
            ready_nxt      = 1'b0;
            terr_nxt       = 1'b0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    pll_resetb_nxt = 1'b0;
                    ch_nxt         = '0;
                    ready_nxt      = 1'b0;
                    if (cnt_q == RST_LAST) begin
                        state_nxt      = ST_WAIT_LOCK;
                        cnt_nxt        = '0;
                        pll_resetb_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_nxt      = ST_PLL_RST;
                        cnt_nxt        = '0;
                        pll_resetb_nxt = 1'b0;
                        terr_nxt       = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = '0;
                        ch_nxt    = '0;
                        ch_nxt[0] = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt      = ST_PLL_RST;
                        cnt_nxt        = '0;
                        ch_nxt         = '0;
                        pll_resetb_nxt = 1'b0;
                        ready_nxt      = 1'b0;
                        if (~&lock_loss_count) begin
                            loss_nxt = lock_loss_count + 1'b1;
                        end
                    end else if (state_q == ST_RELEASE) begin
                        if (&ch_reset_n) begin
                            state_nxt = ST_RUN;
                            cnt_nxt   = '0;
                            ready_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                            ch_nxt  = rls_mask;
                        end
                    end
                end
                default: begin
                    state_nxt      = ST_PLL_RST;
                    cnt_nxt        = '0;
                    ch_nxt         = '0;
                    pll_resetb_nxt = 1'b0;
                    ready_nxt      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_PLL_RST;
            cnt_q           <= '0;
            ch_reset_n      <= '0;
            pll_resetb      <= 1'b0;
            all_ready       <= 1'b0;
            lock_loss_count <= '0;
            timeout_err     <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            cnt_q           <= cnt_nxt;
            ch_reset_n      <= ch_nxt;
            pll_resetb      <= pll_resetb_nxt;
            all_ready       <= ready_nxt;
            lock_loss_count <= loss_nxt;
            timeout_err     <= terr_nxt;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: lock sequence, timeout retry, glitch, loss, saturation.
// Inputs driven and outputs sampled on the falling edge of clock_in.
// No flow control in this block.
module tb_pll_lock_sequencer;
    import clock_pkg::*;

    localparam int NUM_CH         = 3;
    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int STABLE_CYCLES  = 8;
    localparam int STAGGER_CYCLES = 4;
    localparam int LOSS_W         = 8;

    logic              clock_in = 1'b0;
    logic              reset_n;
    logic              pll_locked;
    logic              soft_reset_req;
    logic              pll_resetb;
    logic [NUM_CH-1:0] ch_reset_n;
    logic              all_ready;
    logic [LOSS_W-1:0] lock_loss_count;
    logic              timeout_err;
    logic [2:0]        state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock_in = ~clock_in;

    pll_lock_sequencer #(
        .NUM_CH         (NUM_CH),
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .STAGGER_CYCLES (STAGGER_CYCLES),
        .LOSS_W         (LOSS_W)
    ) dut (
        .clock_in        (clock_in),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .soft_reset_req  (soft_reset_req),
        .pll_resetb      (pll_resetb),
        .ch_reset_n      (ch_reset_n),
        .all_ready       (all_ready),
        .lock_loss_count (lock_loss_count),
        .timeout_err     (timeout_err),
        .state_dbg       (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int i;
        i = 0;
        while (state_dbg !== s && i < budget) begin
            cyc(1);
            i++;
        end
        check(tag, 32'(state_dbg), 32'(s));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        cyc(2);
        check("rst_resetb", 32'(pll_resetb), 32'd0);
        check("rst_ch", 32'(ch_reset_n), 32'd0);
        check("rst_ready", 32'(all_ready), 32'd0);
        check("rst_loss", 32'(lock_loss_count), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_PLL_RST));

        // Normal bring-up; cycle numbers count rising edges after reset release.
        reset_n = 1'b1;
        cyc(3);
        check("seq_resetb_c3", 32'(pll_resetb), 32'd0);
        check("seq_state_c3", 32'(state_dbg), 32'(ST_PLL_RST));
        cyc(1);
        check("seq_resetb_c4", 32'(pll_resetb), 32'd1);
        check("seq_state_c4", 32'(state_dbg), 32'(ST_WAIT_LOCK));
        cyc(5);
        pll_locked = 1'b1;
        cyc(3);
        check("seq_stable_c12", 32'(state_dbg), 32'(ST_STABLE));
        cyc(7);
        check("seq_stable_c19", 32'(state_dbg), 32'(ST_STABLE));
        check("seq_ch_c19", 32'(ch_reset_n), 32'b000);
        cyc(1);
        check("seq_rel_c20", 32'(state_dbg), 32'(ST_RELEASE));
        check("seq_ch_c20", 32'(ch_reset_n), 32'b001);
        cyc(3);
        check("seq_ch_c23", 32'(ch_reset_n), 32'b001);
        cyc(1);
        check("seq_ch_c24", 32'(ch_reset_n), 32'b011);
        cyc(4);
        check("seq_ch_c28", 32'(ch_reset_n), 32'b111);
        check("seq_ready_c28", 32'(all_ready), 32'd0);
        cyc(1);
        check("seq_ready_c29", 32'(all_ready), 32'd1);
        check("seq_run_c29", 32'(state_dbg), 32'(ST_RUN));
        check("seq_resetb_c29", 32'(pll_resetb), 32'd1);

        // Lock drop in RUN.
        pll_locked = 1'b0;
        cyc(2);
        check("drop_ch_p2", 32'(ch_reset_n), 32'b111);
        cyc(1);
        check("drop_ch_p3", 32'(ch_reset_n), 32'b000);
        check("drop_ready", 32'(all_ready), 32'd0);
        check("drop_loss", 32'(lock_loss_count), 32'd1);
        check("drop_state", 32'(state_dbg), 32'(ST_PLL_RST));
        check("drop_resetb", 32'(pll_resetb), 32'd0);

        // Three-clock glitch during STABLE.
        pll_locked = 1'b1;
        cyc(5);
        check("glitch_stable_in", 32'(state_dbg), 32'(ST_STABLE));
        cyc(2);
        pll_locked = 1'b0;
        cyc(3);
        check("glitch_wait", 32'(state_dbg), 32'(ST_WAIT_LOCK));
        check("glitch_loss", 32'(lock_loss_count), 32'd1);
        pll_locked = 1'b1;
        cyc(10);
        check("glitch_restart", 32'(state_dbg), 32'(ST_STABLE));
        cyc(1);
        check("glitch_release", 32'(state_dbg), 32'(ST_RELEASE));
        cyc(9);
        check("glitch_run", 32'(state_dbg), 32'(ST_RUN));

        // Lock timeout and retry.
        pll_locked = 1'b0;
        cyc(3);
        check("tmo_loss", 32'(lock_loss_count), 32'd2);
        cyc(4);
        check("tmo_wait_in", 32'(state_dbg), 32'(ST_WAIT_LOCK));
        cyc(31);
        check("tmo_wait_last", 32'(state_dbg), 32'(ST_WAIT_LOCK));
        check("tmo_terr_pre", 32'(timeout_err), 32'd0);
        cyc(1);
        check("tmo_state", 32'(state_dbg), 32'(ST_PLL_RST));
        check("tmo_terr", 32'(timeout_err), 32'd1);
        check("tmo_resetb", 32'(pll_resetb), 32'd0);
        cyc(3);
        check("tmo_resetb_p3", 32'(pll_resetb), 32'd0);
        cyc(1);
        check("tmo_resetb_p4", 32'(pll_resetb), 32'd1);
        pll_locked = 1'b1;
        cyc(3);
        check("tmo_stable", 32'(state_dbg), 32'(ST_STABLE));
        cyc(8);
        check("tmo_release", 32'(state_dbg), 32'(ST_RELEASE));
        cyc(9);
        check("tmo_run", 32'(state_dbg), 32'(ST_RUN));
        check("tmo_ready", 32'(all_ready), 32'd1);
        check("tmo_terr_sticky", 32'(timeout_err), 32'd1);

        // Soft reset coincident with lock loss in RUN.
        pll_locked = 1'b0;
        cyc(2);
        check("soft_ch_pre", 32'(ch_reset_n), 32'b111);
        soft_reset_req = 1'b1;
        cyc(1);
        soft_reset_req = 1'b0;
        check("soft_state", 32'(state_dbg), 32'(ST_PLL_RST));
        check("soft_loss", 32'(lock_loss_count), 32'd2);
        check("soft_terr", 32'(timeout_err), 32'd0);
        check("soft_ch", 32'(ch_reset_n), 32'b000);
        check("soft_ready", 32'(all_ready), 32'd0);

        // Drive the loss counter past saturation: 300 losses in total.
        for (int i = 0; i < 298; i++) begin
            pll_locked = 1'b1;
            wait_state("sat_run", ST_RUN, 80);
            pll_locked = 1'b0;
            cyc(1);
            pll_locked = 1'b1;
            wait_state("sat_rst", ST_PLL_RST, 10);
            check("sat_cnt", 32'(lock_loss_count), (i + 3 > 255) ? 32'd255 : 32'(i + 3));
        end
        check("sat_final", 32'(lock_loss_count), 32'd255);

        // Asynchronous reset mid-sequence, then a full PLL reset period.
        wait_state("mid_stable", ST_STABLE, 20);
        reset_n = 1'b0;
        #1;
        check("mid_state", 32'(state_dbg), 32'(ST_PLL_RST));
        check("mid_loss", 32'(lock_loss_count), 32'd0);
        check("mid_resetb", 32'(pll_resetb), 32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(3);
        check("mid_resetb_c3", 32'(pll_resetb), 32'd0);
        cyc(1);
        check("mid_resetb_c4", 32'(pll_resetb), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of downstream reset channels (1..8).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 8, PLL RESETB low time in clocks.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536, clocks allowed in WAIT_LOCK before retry.
REQ-004 SHALL have parameter STABLE_CYCLES, default 1024, consecutive synced-lock clocks required before release.
REQ-005 SHALL have parameter STAGGER_CYCLES, default 16, clocks between successive channel releases.
REQ-006 SHALL have parameter LOSS_W, default 8, width of the lock-loss counter.
REQ-007 SHALL have port clock_in, input, 1: reference clock (PLL input clock, not PLL output).
REQ-008 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port pll_locked, input, 1: raw asynchronous PLL LOCK.
REQ-010 SHALL have port soft_reset_req, input, 1: single-cycle request to re-sequence from scratch.
REQ-011 SHALL have port pll_resetb, output, 1: drives PLL RESETB, active-low.
REQ-012 SHALL have port ch_reset_n, output, NUM_CH: per-channel active-low resets.
REQ-013 SHALL have port all_ready, output, 1: high when all channels released and locked.
REQ-014 SHALL have port lock_loss_count, output, LOSS_W: saturating count of lock losses.
REQ-015 SHALL have port timeout_err, output, 1: sticky lock-timeout flag.
REQ-016 SHALL have port state_dbg, output, 3: current FSM state encoding.

Function
REQ-017 pll_locked SHALL pass through a 2-flop synchroniser; lock_s lags pll_locked by 2 clocks.
REQ-018 FSM states: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN; all outputs registered.
REQ-019 PLL_RST: pll_resetb=0, all ch_reset_n=0; after exactly PLL_RST_CYCLES clocks -> WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_resetb=1; lock_s=1 -> STABLE; else if LOCK_TIMEOUT clocks elapse -> timeout_err=1, PLL_RST (retry, unbounded).
REQ-021 STABLE: count consecutive lock_s=1; lock_s=0 -> WAIT_LOCK with timeout counter restarted, no loss increment; STABLE_CYCLES reached -> RELEASE.
REQ-022 RELEASE: ch_reset_n[k] SHALL go high k*STAGGER_CYCLES clocks after RELEASE entry (ch 0 on the first RELEASE clock); once bit NUM_CH-1 is high -> RUN.
REQ-023 RUN: all_ready=1, pll_resetb=1, ch_reset_n all ones.
REQ-024 lock_s=0 in RELEASE or RUN SHALL, on the next clock, drive all ch_reset_n=0, all_ready=0, increment lock_loss_count, enter PLL_RST.
REQ-025 lock_loss_count SHALL saturate at 2^LOSS_W-1 (no wrap).
REQ-026 soft_reset_req=1 in any state SHALL force PLL_RST next clock, all ch_reset_n=0, clear timeout_err, no loss increment.
REQ-027 soft_reset_req SHALL take priority over a simultaneous lock loss (count unchanged).
REQ-028 timeout_err SHALL remain set through subsequent successful lock; cleared only by reset_n or soft_reset_req.
REQ-029 Internal counters SHALL be sized $clog2 of their largest parameter; no counter may wrap within a state.

Reset
REQ-030 reset_n low SHALL asynchronously force: state PLL_RST, pll_resetb=0, ch_reset_n=0, all_ready=0, lock_loss_count=0, timeout_err=0, counters 0, synchroniser flops 0.
REQ-031 Release of reset_n mid-sequence SHALL restart from PLL_RST with full PLL_RST_CYCLES.

Structure
REQ-032 State encodings and the 3-bit state width SHALL live in shared package clock_pkg.
REQ-033 The 2-flop synchroniser SHALL be sub-module sync_2ff, reusable elsewhere in the design.
REQ-034 Single clock domain; no gated or derived clocks inside the block.

Verification (NUM_CH=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, STAGGER_CYCLES=4)
REQ-035 Reset release, pll_locked high from cycle 10 -> pll_resetb high at cycle 4; ch_reset_n = 001, 011, 111 at RELEASE+0/+4/+8; then all_ready=1.
REQ-036 pll_locked held low -> timeout_err=1 after 32 WAIT_LOCK clocks, pll_resetb low 4 clocks, retry; later lock -> full sequence completes, timeout_err still 1.
REQ-037 Lock glitch low 3 clocks during STABLE -> return to WAIT_LOCK, lock_loss_count stays 0, STABLE count restarts from 0.
REQ-038 Lock drop in RUN -> ch_reset_n=000 and all_ready=0 within 3 clocks of pll_locked falling, lock_loss_count=1, PLL_RST entered.
REQ-039 Force 300 lock losses with LOSS_W=8 -> lock_loss_count holds 255.
REQ-040 soft_reset_req coincident with lock loss in RUN -> PLL_RST, lock_loss_count unchanged, timeout_err cleared.
